// File: rtl/uart_pkg.sv
// Shared UART constants and the elaboration-time divisor helper.
package uart_pkg;

    localparam int UART_INT_W_DEF   = 16;
    localparam int UART_FRAC_W_DEF  = 8;
    localparam int UART_DIV_MIN_INT = 2;

    // Rounded clk cycles per os_tick, fixed point with frac_w fractional bits.
    function automatic logic [63:0] calc_div_def(input logic [63:0] clk_hz,
                                                 input logic [63:0] baud,
                                                 input logic [63:0] oversample,
                                                 input int          frac_w);
        logic [63:0] den;
        den = baud * oversample;
        return ((clk_hz << frac_w) + (den >> 1)) / den;
    endfunction

endpackage

// File: rtl/uart_baud_gen_frac.sv
// Fractional-N UART baud generator: os_tick every div_active/2^FRAC_W clocks
// on average, bit_tick every OVERSAMPLE os_ticks, glitch-free divisor updates.
module uart_baud_gen_frac
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int BAUD_DEF    = 115200,
    parameter int OVERSAMPLE  = 16,
    parameter int FRAC_W      = UART_FRAC_W_DEF,
    parameter int INT_W       = UART_INT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    resync,
    input  logic                    cfg_wr,
    input  logic [INT_W+FRAC_W-1:0] cfg_div,
    output logic                    cfg_busy,
    output logic                    cfg_err,
    output logic                    os_tick,
    output logic                    bit_tick,
    output logic [INT_W+FRAC_W-1:0] div_active
);

    localparam int DIV_W = INT_W + FRAC_W;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam logic [DIV_W-1:0] DIV_DEF = DIV_W'(calc_div_def(64'(CLK_FREQ_HZ), 64'(BAUD_DEF),
                                                               64'(OVERSAMPLE), FRAC_W));
    localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_HALF = OS_W'(OVERSAMPLE / 2);
    localparam logic [INT_W-1:0] MIN_INT = INT_W'(UART_DIV_MIN_INT);

    logic [INT_W-1:0]  cnt_q, cnt_d;
    logic [FRAC_W-1:0] acc_q, acc_d;
    logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  shadow_q, shadow_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;
    logic              os_tick_q, os_tick_d;
    logic              bit_tick_q, bit_tick_d;

    logic [INT_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic [FRAC_W-1:0] acc_base;
    logic [FRAC_W:0]   acc_sum;
    logic [INT_W-1:0]  per_last;
    logic              start;
    logic              xfer;
    logic              wr_ok;

    assign div_int  = div_q[DIV_W-1:FRAC_W];
    assign div_frac = div_q[FRAC_W-1:0];

    // cnt_q == 0 marks the cycle that loads a new period; resync forces that
    // cycle with a cleared accumulator, which also swallows a pending tick.
    assign start    = resync || (cnt_q == '0);
    assign acc_base = resync ? {FRAC_W{1'b0}} : acc_q;
    assign acc_sum  = {1'b0, acc_base} + {1'b0, div_frac};
    assign per_last = div_int - INT_W'(1) + INT_W'(acc_sum[FRAC_W]);

    always_comb begin
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        os_cnt_d   = os_cnt_q;
        os_tick_d  = 1'b0;
        bit_tick_d = 1'b0;
        if (!en) begin
            cnt_d    = '0;
            acc_d    = '0;
            os_cnt_d = '0;
        end else if (start) begin
            cnt_d = per_last;
            acc_d = acc_sum[FRAC_W-1:0];
            if (resync) begin
                os_cnt_d = OS_HALF;
            end
        end else begin
            cnt_d = cnt_q - INT_W'(1);
            if (cnt_q == INT_W'(1)) begin
                os_tick_d  = 1'b1;
                bit_tick_d = (os_cnt_q == OS_LAST);
                os_cnt_d   = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);
            end
        end
    end

    // Config handshake: cfg_wr is a one-cycle strobe that is never stalled.
    // An accepted value sits in the shadow with cfg_busy=1 until the next
    // period boundary (or the next cycle while disabled); a rejected value
    // leaves shadow and cfg_busy alone and pulses cfg_err.
    always_comb begin
        wr_ok    = cfg_wr && (cfg_div[DIV_W-1:FRAC_W] >= MIN_INT);
        xfer     = busy_q && (os_tick_d || !en);
        div_d    = xfer ? shadow_q : div_q;
        shadow_d = wr_ok ? cfg_div : shadow_q;
        busy_d   = wr_ok ? 1'b1 : (xfer ? 1'b0 : busy_q);
        err_d    = cfg_wr && !wr_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            os_cnt_q   <= '0;
            div_q      <= DIV_DEF;
            shadow_q   <= DIV_DEF;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            os_tick_q  <= 1'b0;
            bit_tick_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            os_cnt_q   <= os_cnt_d;
            div_q      <= div_d;
            shadow_q   <= shadow_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            os_tick_q  <= os_tick_d;
            bit_tick_q <= bit_tick_d;
        end
    end

    assign os_tick    = os_tick_q;
    assign bit_tick   = bit_tick_q;
    assign cfg_busy   = busy_q;
    assign cfg_err    = err_q;
    assign div_active = div_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Directed bench for uart_baud_gen_frac with default parameters (div 27.125).
module tb_uart_baud_gen_frac;

    localparam logic [23:0] DIV_DEF_EXP = 24'h001B20;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        resync;
    logic        cfg_wr;
    logic [23:0] cfg_div;
    logic        cfg_busy;
    logic        cfg_err;
    logic        os_tick;
    logic        bit_tick;
    logic [23:0] div_active;

    int checks = 0;
    int errors = 0;

    uart_baud_gen_frac dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .resync     (resync),
        .cfg_wr     (cfg_wr),
        .cfg_div    (cfg_div),
        .cfg_busy   (cfg_busy),
        .cfg_err    (cfg_err),
        .os_tick    (os_tick),
        .bit_tick   (bit_tick),
        .div_active (div_active)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input int limit, input string name, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (os_tick !== 1'b1 && n < limit);
        checks++;
        if (os_tick !== 1'b1) begin
            errors++;
            $display("FAIL %s: no os_tick within %0d clks", name, limit);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; resync = 1'b0; cfg_wr = 1'b0; cfg_div = '0;
        step(); step();
        checks++; if (os_tick !== 1'b0) begin errors++; $display("FAIL rst_os_tick: got %b want 0", os_tick); end
        checks++; if (bit_tick !== 1'b0) begin errors++; $display("FAIL rst_bit_tick: got %b want 0", bit_tick); end
        checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", cfg_busy); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", cfg_err); end
        checks++; if (div_active !== DIV_DEF_EXP) begin errors++; $display("FAIL rst_div: got %h want %h", div_active, DIV_DEF_EXP); end
        rst = 1'b0;
    endtask

    task automatic test_disabled();
        int bad;
        bad = 0;
        en = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (os_tick !== 1'b0 || bit_tick !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL disabled_ticks: got %0d tick cycles want 0", bad); end
    endtask

    task automatic test_default_spacing();
        int tick_t[$];
        int bit_t[$];
        int t, acc, p, exp_t, stray;
        t = 0; stray = 0;
        en = 1'b1;
        while (tick_t.size() < 33 && t < 1200) begin
            step();
            t++;
            if (os_tick === 1'b1) tick_t.push_back(t);
            if (bit_tick === 1'b1) begin
                bit_t.push_back(t);
                if (os_tick !== 1'b1) stray++;
            end
        end
        checks++; if (tick_t.size() != 33) begin errors++; $display("FAIL def_tick_count: got %0d want 33", tick_t.size()); end
        checks++; if (tick_t.size() > 0 && tick_t[0] != 27) begin errors++; $display("FAIL first_tick_after_en: got %0d want 27", tick_t[0]); end
        // Period lengths: 27 + carry of a 0x20-per-period accumulator.
        acc = 0; exp_t = 0;
        for (int k = 0; k < tick_t.size(); k++) begin
            acc = acc + 32;
            p = 27 + acc / 256;
            acc = acc % 256;
            exp_t = exp_t + p;
            checks++;
            if (tick_t[k] != exp_t) begin errors++; $display("FAIL def_tick_%0d: got t=%0d want t=%0d", k, tick_t[k], exp_t); end
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL bit_without_os: got %0d want 0", stray); end
        checks++; if (bit_t.size() != 2) begin errors++; $display("FAIL def_bit_count: got %0d want 2", bit_t.size()); end
        checks++; if (bit_t.size() > 0 && bit_t[0] != 434) begin errors++; $display("FAIL def_bit_0: got %0d want 434", bit_t[0]); end
        checks++; if (bit_t.size() > 1 && bit_t[1] != 868) begin errors++; $display("FAIL def_bit_1: got %0d want 868", bit_t[1]); end
    endtask

    task automatic test_cfg_write();
        int n, bad;
        wait_tick(40, "wr_sync", n);
        step(); step(); step();
        cfg_wr = 1'b1; cfg_div = 24'h000A00;
        step();
        cfg_wr = 1'b0;
        checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL wr_busy_set: got %b want 1", cfg_busy); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL wr_no_err: got %b want 0", cfg_err); end
        n = 0; bad = 0;
        while (os_tick !== 1'b1 && n < 40) begin
            if (cfg_busy !== 1'b1) bad++;
            step();
            n++;
        end
        checks++; if (os_tick !== 1'b1) begin errors++; $display("FAIL wr_tick_seen: got %b want 1", os_tick); end
        checks++; if (bad != 0) begin errors++; $display("FAIL wr_busy_held: got %0d low cycles want 0", bad); end
        checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL wr_busy_clr: got %b want 0", cfg_busy); end
        checks++; if (div_active !== 24'h000A00) begin errors++; $display("FAIL wr_div: got %h want 000a00", div_active); end
        for (int i = 0; i < 3; i++) begin
            wait_tick(40, "wr_spacing", n);
            checks++; if (n != 10) begin errors++; $display("FAIL wr_spacing_%0d: got %0d want 10", i, n); end
        end
    endtask

    task automatic test_resync();
        int os_t[$];
        int bit_t[$];
        int n, t;
        wait_tick(40, "rs_sync", n);
        step(); step(); step(); step();
        resync = 1'b1;
        step();
        resync = 1'b0;
        t = 1;
        while (bit_t.size() < 3 && t < 600) begin
            if (os_tick === 1'b1) os_t.push_back(t);
            if (bit_tick === 1'b1) bit_t.push_back(t);
            step();
            t++;
        end
        checks++; if (os_t.size() == 0 || os_t[0] != 10) begin errors++; $display("FAIL rs_first_os: got %0d want 10", (os_t.size() > 0) ? os_t[0] : -1); end
        checks++; if (bit_t.size() != 3) begin errors++; $display("FAIL rs_bit_count: got %0d want 3", bit_t.size()); end
        checks++; if (bit_t.size() > 0 && bit_t[0] != 80) begin errors++; $display("FAIL rs_bit_0: got %0d want 80", bit_t[0]); end
        checks++; if (bit_t.size() > 1 && bit_t[1] != 240) begin errors++; $display("FAIL rs_bit_1: got %0d want 240", bit_t[1]); end
        checks++; if (bit_t.size() > 2 && bit_t[2] != 400) begin errors++; $display("FAIL rs_bit_2: got %0d want 400", bit_t[2]); end
    endtask

    task automatic test_cfg_reject();
        int n;
        wait_tick(40, "rej_sync", n);
        step();
        cfg_wr = 1'b1; cfg_div = 24'h000180;
        step();
        cfg_wr = 1'b0;
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL rej_err: got %b want 1", cfg_err); end
        checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL rej_busy: got %b want 0", cfg_busy); end
        checks++; if (div_active !== 24'h000A00) begin errors++; $display("FAIL rej_div: got %h want 000a00", div_active); end
        step();
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL rej_err_pulse: got %b want 0", cfg_err); end
        cfg_wr = 1'b1; cfg_div = 24'h000200;
        step();
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL min_accept_err: got %b want 0", cfg_err); end
        checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL min_accept_busy: got %b want 1", cfg_busy); end
        cfg_div = 24'h0001FF;
        step();
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL rej_1ff_err: got %b want 1", cfg_err); end
        checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL rej_1ff_busy: got %b want 1", cfg_busy); end
        cfg_div = 24'h000B00;
        step();
        cfg_wr = 1'b0;
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL overwrite_err: got %b want 0", cfg_err); end
        wait_tick(40, "overwrite_apply", n);
        checks++; if (div_active !== 24'h000B00) begin errors++; $display("FAIL overwrite_div: got %h want 000b00", div_active); end
        checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL overwrite_busy: got %b want 0", cfg_busy); end
        wait_tick(40, "overwrite_spacing", n);
        checks++; if (n != 11) begin errors++; $display("FAIL overwrite_spacing: got %0d want 11", n); end
    endtask

    task automatic test_back_to_back();
        int n;
        // Second write lands in the cycle that raises os_tick.
        step(); step();
        cfg_wr = 1'b1; cfg_div = 24'h000C00;
        step();
        cfg_wr = 1'b0;
        repeat (7) step();
        cfg_wr = 1'b1; cfg_div = 24'h000E00;
        step();
        cfg_wr = 1'b0;
        checks++; if (os_tick !== 1'b1) begin errors++; $display("FAIL b2b_tick: got %b want 1", os_tick); end
        checks++; if (div_active !== 24'h000C00) begin errors++; $display("FAIL b2b_div_old: got %h want 000c00", div_active); end
        checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", cfg_busy); end
        wait_tick(40, "b2b_next", n);
        checks++; if (n != 12) begin errors++; $display("FAIL b2b_spacing_12: got %0d want 12", n); end
        checks++; if (div_active !== 24'h000E00) begin errors++; $display("FAIL b2b_div_new: got %h want 000e00", div_active); end
        checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_clr: got %b want 0", cfg_busy); end
        wait_tick(40, "b2b_next2", n);
        checks++; if (n != 14) begin errors++; $display("FAIL b2b_spacing_14: got %0d want 14", n); end
    endtask

    task automatic test_resync_priority();
        int n;
        // Resync lands in the cycle that would raise os_tick.
        step(); step();
        cfg_wr = 1'b1; cfg_div = 24'h000A00;
        step();
        cfg_wr = 1'b0;
        repeat (10) step();
        resync = 1'b1;
        step();
        resync = 1'b0;
        checks++; if (os_tick !== 1'b0) begin errors++; $display("FAIL prio_tick_supp: got %b want 0", os_tick); end
        checks++; if (div_active !== 24'h000E00) begin errors++; $display("FAIL prio_div_held: got %h want 000e00", div_active); end
        checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL prio_busy: got %b want 1", cfg_busy); end
        wait_tick(40, "prio_next", n);
        checks++; if (n != 13) begin errors++; $display("FAIL prio_spacing: got %0d want 13", n); end
        checks++; if (div_active !== 24'h000A00) begin errors++; $display("FAIL prio_div_new: got %h want 000a00", div_active); end
        checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL prio_busy_clr: got %b want 0", cfg_busy); end
        wait_tick(40, "prio_next2", n);
        checks++; if (n != 10) begin errors++; $display("FAIL prio_spacing_10: got %0d want 10", n); end
    endtask

    task automatic test_rst_pending();
        int n;
        step(); step();
        cfg_wr = 1'b1; cfg_div = 24'h001000;
        step();
        cfg_wr = 1'b0;
        checks++; if (cfg_busy !== 1'b1) begin errors++; $display("FAIL rstp_busy: got %b want 1", cfg_busy); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (os_tick !== 1'b0) begin errors++; $display("FAIL rstp_os_tick: got %b want 0", os_tick); end
        checks++; if (bit_tick !== 1'b0) begin errors++; $display("FAIL rstp_bit_tick: got %b want 0", bit_tick); end
        checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL rstp_busy_clr: got %b want 0", cfg_busy); end
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL rstp_err: got %b want 0", cfg_err); end
        checks++; if (div_active !== DIV_DEF_EXP) begin errors++; $display("FAIL rstp_div: got %h want %h", div_active, DIV_DEF_EXP); end
        wait_tick(60, "rstp_first", n);
        checks++; if (n != 27) begin errors++; $display("FAIL rstp_first_spacing: got %0d want 27", n); end
        checks++; if (div_active !== DIV_DEF_EXP) begin errors++; $display("FAIL rstp_div_kept: got %h want %h", div_active, DIV_DEF_EXP); end
        wait_tick(60, "rstp_second", n);
        checks++; if (n != 27) begin errors++; $display("FAIL rstp_second_spacing: got %0d want 27", n); end
        checks++; if (cfg_busy !== 1'b0) begin errors++; $display("FAIL rstp_busy_final: got %b want 0", cfg_busy); end
    endtask

    initial begin
        test_reset();
        test_disabled();
        test_default_spacing();
        test_cfg_write();
        test_resync();
        test_cfg_reject();
        test_back_to_back();
        test_resync_priority();
        test_rst_pending();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
